// File: rtl/da_serial_ctrl.sv
// Sequencer for the bit-serial distributed-arithmetic filter: loads a sample into
// the tap shift registers, steps DATA_W serial cycles, then holds the result for handoff.
module da_serial_ctrl #(
    parameter int DATA_W = 20,
    parameter int CNT_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sr_we,
    output logic             sr_en,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             acc_sub,
    output logic [CNT_W-1:0] bit_idx,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

    state_t           r_state;
    state_t           w_stateNext;
    logic [CNT_W-1:0] r_bitIdx;
    logic [CNT_W-1:0] w_bitIdxNext;
    logic             w_accept;
    logic             w_lastBit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_bitIdx <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_bitIdx <= w_bitIdxNext;
        end
    end

    // Outputs are forced low during reset so nothing downstream sees a stray strobe.
    always_comb begin
        w_stateNext  = r_state;
        w_bitIdxNext = r_bitIdx;
        in_ready     = 1'b0;
        sr_en        = 1'b0;
        acc_en       = 1'b0;
        acc_sub      = 1'b0;
        bit_idx      = '0;
        busy         = 1'b0;
        out_valid    = 1'b0;
        w_lastBit    = (r_bitIdx == LAST_IDX);

        if (!rst) begin
            busy = (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    in_ready = 1'b1;
                end
                SHIFT: begin
                    sr_en   = 1'b1;
                    acc_en  = 1'b1;
                    acc_sub = w_lastBit;
                    bit_idx = r_bitIdx;
                end
                DONE: begin
                    out_valid = 1'b1;
                    in_ready  = out_ready;
                end
                default: begin
                    in_ready = 1'b0;
                end
            endcase
        end

        w_accept = in_valid & in_ready;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_stateNext  = SHIFT;
                    w_bitIdxNext = '0;
                end
            end
            SHIFT: begin
                if (w_lastBit) begin
                    w_stateNext  = DONE;
                    w_bitIdxNext = '0;
                end else begin
                    w_bitIdxNext = r_bitIdx + 1'b1;
                end
            end
            DONE: begin
                // A new sample may be taken in the same cycle the result is consumed.
                if (w_accept) begin
                    w_stateNext  = SHIFT;
                    w_bitIdxNext = '0;
                end else if (out_ready) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext  = IDLE;
                w_bitIdxNext = '0;
            end
        endcase
    end

    assign sr_we   = w_accept;
    assign acc_clr = w_accept;

endmodule
